// File: rtl/adder3_accum.sv
// Burst accumulator: sums a run of 3-bit beats of programmable length (1..8)
// into an ACC_W-bit total with sticky wrap flag, handshaked on both sides.
module adder3_accum #(
  parameter int ACC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       len_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             in_fire;
  logic             out_fire;
  logic [3:0]       len_eff;
  logic [3:0]       cnt_inc;
  logic [ACC_W:0]   sum_in_ext;
  logic [ACC_W:0]   sum_ext;

  assign in_ready   = !rst && (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  // A length code of 0 encodes the maximum burst of 8 beats.
  assign len_eff    = (len_in == 3'd0) ? 4'd8 : {1'b0, len_in};
  assign cnt_inc    = cnt_q + 4'd1;
  assign sum_in_ext = {{(ACC_W-2){1'b0}}, sum_in};
  // One extra bit catches the carry out of the accumulator's MSB.
  assign sum_ext    = {1'b0, acc_q} + sum_in_ext;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          len_d   = len_eff;
          acc_d   = sum_in_ext[ACC_W-1:0];
          cnt_d   = 4'd1;
          ovf_d   = 1'b0;
          state_d = (len_eff == 4'd1) ? HOLD : ACCUM;
        end
      end

      ACCUM: begin
        if (in_fire) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_fire) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 4'd0;
      len_q   <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adder3_accum.sv
// Directed bench for adder3_accum: a default-width and a 4-bit instance share
// one stimulus stream so the wrap case is observed alongside the normal one.
module tb_adder3_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sum_in;
  logic       in_valid;
  logic [2:0] len_in;
  logic       out_ready;

  logic       in_ready6, out_valid6, ovf6;
  logic [5:0] acc6;
  logic       in_ready4, out_valid4, ovf4;
  logic [3:0] acc4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adder3_accum dut6 (
    .clk      (clk),
    .rst      (rst),
    .sum_in   (sum_in),
    .in_valid (in_valid),
    .in_ready (in_ready6),
    .len_in   (len_in),
    .acc_out  (acc6),
    .out_valid(out_valid6),
    .out_ready(out_ready),
    .ovf      (ovf6)
  );

  adder3_accum #(.ACC_W(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .sum_in   (sum_in),
    .in_valid (in_valid),
    .in_ready (in_ready4),
    .len_in   (len_in),
    .acc_out  (acc4),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .ovf      (ovf4)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] v);
    in_valid = 1'b1;
    sum_in   = v;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    sum_in    = 3'd0;
    in_valid  = 1'b0;
    len_in    = 3'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready6, 0);
    check("rst_out_valid", out_valid6, 0);
    check("rst_acc", acc6, 0);
    check("rst_ovf", ovf6, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready6, 1);

    // Length 4, beats 1..4 back to back, result taken immediately.
    out_ready = 1'b1;
    len_in    = 3'd4;
    beat(3'd1);
    check("b4_partial1", acc6, 1);
    beat(3'd2);
    check("b4_partial2", acc6, 3);
    check("b4_no_valid", out_valid6, 0);
    beat(3'd3);
    beat(3'd4);
    in_valid = 1'b0;
    check("b4_valid", out_valid6, 1);
    check("b4_acc", acc6, 10);
    check("b4_ovf", ovf6, 0);
    check("b4_in_ready_hold", in_ready6, 0);
    tick();
    check("b4_valid_one_cycle", out_valid6, 0);
    check("b4_acc_cleared", acc6, 0);

    // Length code 0 means 8 beats of 7: 56 at 6 bits, wraps to 8 at 4 bits.
    out_ready = 1'b0;
    len_in    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      beat(3'd7);
      if (i == 2) begin
        check("b8_w4_partial", acc4, 5);
        check("b8_w4_ovf_early", ovf4, 1);
      end
      if (i == 6) begin
        check("b8_before_last", out_valid6, 0);
        check("b8_partial7", acc6, 49);
      end
    end
    in_valid = 1'b0;
    check("b8_valid", out_valid6, 1);
    check("b8_acc", acc6, 56);
    check("b8_ovf", ovf6, 0);
    check("b8_w4_acc", acc4, 8);
    check("b8_w4_ovf", ovf4, 1);
    out_ready = 1'b1;
    tick();
    check("b8_w4_ovf_cleared", ovf4, 0);
    check("b8_released", out_valid6, 0);

    // Back-pressure: held result must not absorb beats offered meanwhile.
    out_ready = 1'b0;
    len_in    = 3'd2;
    beat(3'd5);
    beat(3'd6);
    check("bp_valid", out_valid6, 1);
    check("bp_acc", acc6, 11);
    sum_in = 3'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_acc", acc6, 11);
      check("bp_hold_ready", in_ready6, 0);
    end
    check("bp_hold_valid", out_valid6, 1);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid6, 0);
    check("bp_release_acc", acc6, 0);
    check("bp_release_ready", in_ready6, 1);
    out_ready = 1'b0;
    len_in    = 3'd1;
    beat(3'd3);
    in_valid = 1'b0;
    check("bp_new_burst_valid", out_valid6, 1);
    check("bp_new_burst_acc", acc6, 3);
    out_ready = 1'b1;
    tick();

    // Gaps in in_valid, len_in changed after the first beat.
    out_ready = 1'b0;
    len_in    = 3'd3;
    beat(3'd2);
    in_valid = 1'b0;
    len_in   = 3'd1;
    tick();
    tick();
    tick();
    check("gap_acc_held", acc6, 2);
    check("gap_no_valid", out_valid6, 0);
    beat(3'd4);
    in_valid = 1'b0;
    check("gap_acc2", acc6, 6);
    check("gap_len_ignored", out_valid6, 0);
    tick();
    beat(3'd1);
    in_valid = 1'b0;
    check("gap_valid", out_valid6, 1);
    check("gap_acc", acc6, 7);
    out_ready = 1'b1;
    tick();

    // Reset mid-burst and in HOLD discards the partial/held total.
    out_ready = 1'b0;
    len_in    = 3'd4;
    beat(3'd2);
    beat(3'd3);
    in_valid = 1'b0;
    check("mid_partial", acc6, 5);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", out_valid6, 0);
    check("mid_rst_acc", acc6, 0);
    check("mid_rst_in_ready", in_ready6, 0);
    rst    = 1'b0;
    len_in = 3'd1;
    beat(3'd5);
    in_valid = 1'b0;
    check("post_rst_acc", acc6, 5);
    check("post_rst_valid", out_valid6, 1);
    rst = 1'b1;
    tick();
    check("hold_rst_valid", out_valid6, 0);
    check("hold_rst_acc", acc6, 0);
    rst = 1'b0;
    tick();
    check("hold_rst_idle_ready", in_ready6, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
